// File: rtl/hv_timing_tx.sv
// hv_timing_tx: raster timing generator producing HSYNC/VSYNC/DE/FID, xpos/ypos and SOF.
// Interlaced operation is compiled in only when HV_TX_INTERLACE_EN is defined.
module hv_timing_tx #(
  parameter int CFG_MIN_HTOTAL = 16,
  parameter int CFG_MIN_VTOTAL = 2
) (
  input  logic        PCLK_i,
  input  logic        reset_n,
  input  logic        enable_i,
  input  logic        resync_i,
  input  logic [31:0] hv_out_config,
  input  logic [31:0] hv_out_config2,
  input  logic [31:0] hv_out_config3,
  output logic        HSYNC_o,
  output logic        VSYNC_o,
  output logic        DE_o,
  output logic        FID_o,
  output logic [10:0] xpos_o,
  output logic [10:0] ypos_o,
  output logic        sof_o,
  output logic        config_err_o
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t      state_q;
  logic [11:0] h_cnt_q;
  logic [10:0] v_cnt_q;
  logic        fid_q;
  logic [31:0] cfg1_q, cfg2_q, cfg3_q;
  logic        hsync_q, vsync_q, de_q, fid_out_q, sof_q, err_q;
  logic [10:0] xpos_q, ypos_q;

  logic [11:0] h_total, h_active;
  logic [7:0]  h_synclen, v_resync;
  logic [8:0]  h_bp, v_bp;
  logic [10:0] v_total, v_active, v_sof;
  logic [3:0]  v_synclen;

  assign h_total   = cfg1_q[11:0];
  assign h_active  = cfg1_q[23:12];
  assign h_synclen = cfg1_q[31:24];
  assign h_bp      = cfg2_q[8:0];
  assign v_total   = cfg2_q[19:9];
  assign v_active  = cfg2_q[30:20];
  assign v_synclen = cfg3_q[3:0];
  assign v_bp      = cfg3_q[12:4];
  assign v_sof     = cfg3_q[23:13];
  assign v_resync  = cfg3_q[31:24];

`ifdef HV_TX_INTERLACE_EN
  logic        interlaced;
  logic [11:0] h_half;
  logic        vs_low;
  assign interlaced = cfg2_q[31];
  assign h_half     = h_total >> 1;
`else
  logic ilace_unused;
  assign ilace_unused = cfg2_q[31];
`endif

  logic [12:0] h_start, h_end, v_start, v_end;
  logic [10:0] field_len, resync_line, xpos_d, ypos_d;
  logic        hsync_d, vsync_d, de_d, sof_d, last_px, last_line, cfg_ok;

  always_comb begin
    h_start     = 13'(h_synclen) + 13'(h_bp);
    h_end       = h_start + 13'(h_active);
    v_start     = 13'(v_synclen) + 13'(v_bp);
    v_end       = v_start + 13'(v_active);
    hsync_d     = (h_cnt_q >= 12'(h_synclen));
    de_d        = (13'(h_cnt_q) >= h_start) && (13'(h_cnt_q) < h_end) &&
                  (13'(v_cnt_q) >= v_start) && (13'(v_cnt_q) < v_end);
    xpos_d      = h_cnt_q[10:0] - h_start[10:0];
    ypos_d      = v_cnt_q - v_start[10:0];
    sof_d       = (v_cnt_q == v_sof) && (h_cnt_q == '0);
    last_px     = (h_cnt_q == h_total - 12'd1);
    resync_line = (11'(v_resync) >= v_total) ? '0 : 11'(v_resync);
    cfg_ok      = (hv_out_config[11:0] >= 12'(CFG_MIN_HTOTAL)) &&
                  (hv_out_config2[19:9] >= 11'(CFG_MIN_VTOTAL));
`ifdef HV_TX_INTERLACE_EN
    if (interlaced)
      field_len = fid_q ? 11'((12'(v_total) + 12'd1) >> 1) : (v_total >> 1);
    else
      field_len = v_total;
    // Even fields shift both VSYNC edges by half a line
    if (fid_q)
      vs_low = (v_cnt_q < 11'(v_synclen));
    else if (v_cnt_q < 11'(v_synclen))
      vs_low = (v_cnt_q != '0) || (h_cnt_q >= h_half);
    else
      vs_low = (v_cnt_q == 11'(v_synclen)) && (v_cnt_q != '0) && (h_cnt_q < h_half);
    vsync_d = !vs_low;
`else
    field_len = v_total;
    vsync_d   = !(v_cnt_q < 11'(v_synclen));
`endif
    last_line = (v_cnt_q == field_len - 11'd1);
  end

  always_ff @(posedge PCLK_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      fid_q     <= 1'b1;
      cfg1_q    <= '0;
      cfg2_q    <= '0;
      cfg3_q    <= '0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      de_q      <= 1'b0;
      fid_out_q <= 1'b1;
      sof_q     <= 1'b0;
      err_q     <= 1'b0;
      xpos_q    <= '0;
      ypos_q    <= '0;
    end else begin
      // Output stage: decoded from the current counter state, idle values outside RUN
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      de_q      <= 1'b0;
      fid_out_q <= 1'b1;
      sof_q     <= 1'b0;
      xpos_q    <= '0;
      ypos_q    <= '0;
      if (state_q == RUN) begin
        hsync_q   <= hsync_d;
        vsync_q   <= vsync_d;
        de_q      <= de_d;
        fid_out_q <= fid_q;
        sof_q     <= sof_d;
        xpos_q    <= xpos_d;
        ypos_q    <= ypos_d;
      end
      if (!enable_i) begin
        state_q <= IDLE;
        h_cnt_q <= '0;
        v_cnt_q <= '0;
        fid_q   <= 1'b1;
      end else begin
        case (state_q)
          IDLE: state_q <= LOAD;
          LOAD: begin
            cfg1_q <= hv_out_config;
            cfg2_q <= hv_out_config2;
            cfg3_q <= hv_out_config3;
            if (cfg_ok) begin
              err_q   <= 1'b0;
              h_cnt_q <= '0;
              v_cnt_q <= '0;
              fid_q   <= 1'b1;
              state_q <= RUN;
            end else begin
              err_q <= 1'b1;
            end
          end
          RUN: begin
            if (resync_i) begin
              h_cnt_q <= '0;
              v_cnt_q <= resync_line;
              fid_q   <= 1'b1;
            end else if (last_px) begin
              h_cnt_q <= '0;
              if (last_line) begin
                v_cnt_q <= '0;
`ifdef HV_TX_INTERLACE_EN
                if (interlaced && fid_q) fid_q <= 1'b0;
                else state_q <= LOAD;
`else
                state_q <= LOAD;
`endif
              end else begin
                v_cnt_q <= v_cnt_q + 11'd1;
              end
            end else begin
              h_cnt_q <= h_cnt_q + 12'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign HSYNC_o      = hsync_q;
  assign VSYNC_o      = vsync_q;
  assign DE_o         = de_q;
  assign FID_o        = fid_out_q;
  assign xpos_o       = xpos_q;
  assign ypos_o       = ypos_q;
  assign sof_o        = sof_q;
  assign config_err_o = err_q;
endmodule

// File: tb/tb_hv_timing_tx.sv
// Bench for hv_timing_tx: raster-position model plus directed frame-level expectations.
module tb_hv_timing_tx;
  logic        PCLK_i = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable_i = 1'b0;
  logic        resync_i = 1'b0;
  logic [31:0] cfg1 = '0, cfg2 = '0, cfg3 = '0;
  logic        HSYNC_o, VSYNC_o, DE_o, FID_o, sof_o, config_err_o;
  logic [10:0] xpos_o, ypos_o;

  hv_timing_tx dut (
    .PCLK_i(PCLK_i), .reset_n(reset_n), .enable_i(enable_i), .resync_i(resync_i),
    .hv_out_config(cfg1), .hv_out_config2(cfg2), .hv_out_config3(cfg3),
    .HSYNC_o(HSYNC_o), .VSYNC_o(VSYNC_o), .DE_o(DE_o), .FID_o(FID_o),
    .xpos_o(xpos_o), .ypos_o(ypos_o), .sof_o(sof_o), .config_err_o(config_err_o)
  );

  always #5 PCLK_i = ~PCLK_i;

  int n_pass = 0, n_total = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic timeout(input string name);
    n_total++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // {HSYNC, VSYNC, DE, FID, SOF, ERR, xpos, ypos}
  logic [27:0] dut_vec, exp_vec;
  assign dut_vec = {HSYNC_o, VSYNC_o, DE_o, FID_o, sof_o, config_err_o, xpos_o, ypos_o};

  // Model: position in a field is a linear pixel index plus the starting line.
  int ht, ha, hs, hbp, vt, va, vs, vbp, vsof, vres;
  bit ilace;
  int m_st, m_p, m_vb;   // m_st: 0 idle, 1 load, 2 run
  bit m_fid, m_err;

  function automatic logic [27:0] raster_out(int h, int v, bit fid);
    int q;
    bit hsn, vsn, de, sof;
    logic [10:0] x, y;
    q   = v * ht + h;
    hsn = !(h < hs);
    if (fid) vsn = !(q < vs * ht);
    else     vsn = !(q >= ht / 2 && q < vs * ht + ht / 2);
    de  = (h >= hs + hbp) && (h < hs + hbp + ha) && (v >= vs + vbp) && (v < vs + vbp + va);
    x   = 11'(h - hs - hbp);
    y   = 11'(v - vs - vbp);
    sof = (v == vsof) && (h == 0);
    return {hsn, vsn, de, fid, sof, 1'b0, x, y};
  endfunction

  function automatic int field_lines();
    if (ilace) return m_fid ? (vt + 1) / 2 : vt / 2;
    return vt;
  endfunction

  initial begin
    m_st = 0; m_p = 0; m_vb = 0; m_fid = 1; m_err = 0;
    exp_vec = 28'hD000000;
    forever begin
      @(posedge PCLK_i or negedge reset_n);
      if (!reset_n) begin
        m_st = 0; m_p = 0; m_vb = 0; m_fid = 1; m_err = 0;
        exp_vec = 28'hD000000;
      end else begin
        if (m_st == 2) exp_vec = raster_out(m_p % ht, m_vb + m_p / ht, m_fid);
        else           exp_vec = 28'hD000000;
        if (!enable_i) begin
          m_st = 0; m_p = 0; m_vb = 0; m_fid = 1;
        end else if (m_st == 0) begin
          m_st = 1;
        end else if (m_st == 1) begin
          if (int'(cfg1[11:0]) < 16 || int'(cfg2[19:9]) < 2) m_err = 1;
          else begin
            m_err = 0;
            ht = int'(cfg1[11:0]); ha = int'(cfg1[23:12]); hs = int'(cfg1[31:24]);
            hbp = int'(cfg2[8:0]); vt = int'(cfg2[19:9]); va = int'(cfg2[30:20]);
`ifdef HV_TX_INTERLACE_EN
            ilace = cfg2[31];
`else
            ilace = 0;
`endif
            vs = int'(cfg3[3:0]); vbp = int'(cfg3[12:4]);
            vsof = int'(cfg3[23:13]); vres = int'(cfg3[31:24]);
            m_st = 2; m_p = 0; m_vb = 0; m_fid = 1;
          end
        end else begin
          if (resync_i) begin
            m_p = 0; m_vb = (vres >= vt) ? 0 : vres; m_fid = 1;
          end else begin
            m_p++;
            if (m_p == (field_lines() - m_vb) * ht) begin
              if (ilace && m_fid) begin m_fid = 0; m_p = 0; m_vb = 0; end
              else begin m_st = 1; m_p = 0; m_vb = 0; end
            end
          end
        end
        exp_vec[22] = m_err;
      end
    end
  end

  always @(negedge PCLK_i) if (chk_en) check("raster", 32'(dut_vec), 32'(exp_vec));

  task automatic set_cfg(input int c_ht, c_ha, c_hs, c_hbp, c_vt, c_va, c_il, c_vs, c_vbp, c_sof, c_res);
    cfg1 = {8'(c_hs), 12'(c_ha), 12'(c_ht)};
    cfg2 = {1'(c_il), 11'(c_va), 11'(c_vt), 9'(c_hbp)};
    cfg3 = {8'(c_res), 11'(c_sof), 9'(c_vbp), 4'(c_vs)};
  endtask

  task automatic wait_sof();
    int n = 0;
    do begin @(negedge PCLK_i); n++; end while (!sof_o && n < 500);
    if (!sof_o) timeout("wait_sof");
  endtask

  task automatic wait_de();
    int n = 0;
    do begin @(negedge PCLK_i); n++; end while (!DE_o && n < 500);
    if (!DE_o) timeout("wait_de");
  endtask

  // Counts from the current (SOF) sample up to, not including, the next SOF.
  task automatic measure(output int cyc, output int de, output int hsl, output int vsl);
    cyc = 0; de = 0; hsl = 0; vsl = 0;
    do begin
      de += int'(DE_o); hsl += int'(!HSYNC_o); vsl += int'(!VSYNC_o);
      @(negedge PCLK_i); cyc++;
    end while (!sof_o && cyc < 1000);
  endtask

  task automatic window(input int len, output int de, output int vsl, output int fidl);
    de = 0; vsl = 0; fidl = 0;
    for (int i = 0; i < len; i++) begin
      de += int'(DE_o); vsl += int'(!VSYNC_o); fidl += int'(!FID_o);
      @(negedge PCLK_i);
    end
  endtask

  int cyc, de, hsl, vsl, fidl, n;

  initial begin
    set_cfg(20, 10, 3, 4, 8, 4, 0, 2, 1, 1, 5);
    repeat (3) @(negedge PCLK_i);
    chk_en = 1;
    check("reset_vec", 32'(dut_vec), 32'h0D000000);
    reset_n = 1;
    @(negedge PCLK_i);
    enable_i = 1;

    wait_de();
    check("first_de_xpos", 32'(xpos_o), 0);
    check("first_de_ypos", 32'(ypos_o), 0);
    wait_sof();
    measure(cyc, de, hsl, vsl);
    check("frame_period", cyc, 161);
    check("frame_de", de, 40);
    check("frame_hsync_low", hsl, 24);
    check("frame_vsync_low", vsl, 40);

    // H_ACTIVE 10 -> 8 right after SOF: current frame keeps 10
    set_cfg(20, 8, 3, 4, 8, 4, 0, 2, 1, 1, 5);
    measure(cyc, de, hsl, vsl);
    check("hact_old_frame_de", de, 40);
    measure(cyc, de, hsl, vsl);
    check("hact_new_frame_de", de, 32);

    // Mid-frame resync to line 5
    repeat (40) @(negedge PCLK_i);
    resync_i = 1; @(negedge PCLK_i); resync_i = 0; @(negedge PCLK_i);
    check("resync_ypos", 32'(ypos_o), 2);
    check("resync_xpos", 32'(xpos_o), 2041);

    // Resync on the last pixel of the frame: resync wins, no LOAD stretch
    n = 0;
    while (!(m_st == 2 && m_vb + m_p / ht == vt - 1 && m_p % ht == ht - 1) && n < 400) begin
      @(negedge PCLK_i); n++;
    end
    if (n >= 400) timeout("wait_frame_end");
    resync_i = 1; @(negedge PCLK_i); resync_i = 0; @(negedge PCLK_i);
    check("resync_end_ypos", 32'(ypos_o), 2);
    check("resync_end_hsync", 32'(HSYNC_o), 0);

    // V_RESYNC_LINE >= V_TOTAL clamps to line 0
    wait_sof();
    set_cfg(20, 8, 3, 4, 8, 4, 0, 2, 1, 1, 9);
    wait_sof();
    repeat (10) @(negedge PCLK_i);
    resync_i = 1; @(negedge PCLK_i); resync_i = 0; @(negedge PCLK_i);
    check("resync_clamp_ypos", 32'(ypos_o), 2045);

    // Interlace request: 4/3 line fields when compiled in, 7-line progressive otherwise
    wait_sof();
    set_cfg(20, 10, 3, 4, 7, 2, 1, 1, 0, 1, 0);
    wait_sof();
    window(141, de, vsl, fidl);
`ifdef HV_TX_INTERLACE_EN
    check("ilace_fid_low", fidl, 60);
    check("ilace_vsync_low", vsl, 40);
    check("ilace_de", de, 40);
`else
    check("prog_fid_low", fidl, 0);
    check("prog_vsync_low", vsl, 20);
    check("prog_de", de, 20);
`endif

    // Too-short H_TOTAL: error, idle outputs; a valid word clears it
    enable_i = 0;
    repeat (2) @(negedge PCLK_i);
    set_cfg(8, 4, 1, 1, 8, 4, 0, 2, 1, 1, 5);
    enable_i = 1;
    repeat (4) @(negedge PCLK_i);
    check("cfg_err_vec", 32'(dut_vec), 32'h0D400000);
    set_cfg(20, 10, 3, 4, 8, 4, 0, 2, 1, 1, 5);
    @(negedge PCLK_i);
    check("cfg_err_clear", 32'(config_err_o), 0);
    @(negedge PCLK_i);
    check("run_after_clear_hsync", 32'(HSYNC_o), 0);

    // enable_i dropped during active video
    wait_de();
    enable_i = 0;
    repeat (2) @(negedge PCLK_i);
    check("disable_de", 32'(DE_o), 0);
    enable_i = 1;

    // Asynchronous reset during active video
    wait_de();
    #2 reset_n = 0;
    #1 check("async_reset_vec", 32'(dut_vec), 32'h0D000000);
    @(negedge PCLK_i);
    reset_n = 1;
    repeat (60) @(negedge PCLK_i);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/hv_timing_tx.md
Name: hv_timing_tx

Overview:
Video timing transmitter. It regenerates HSYNC/VSYNC/DE/FID, xpos/ypos and a scaler SOF pulse from programmed raster configuration words. The config word layout is the same one the capture frontend uses. It drives the output pixel pipeline and the external video encoder, and accepts a framelock resync pulse from the input side.

Parameters:
- CFG_MIN_HTOTAL, 16: smallest H_TOTAL accepted at LOAD; below this raises config_err_o.
- CFG_MIN_VTOTAL, 2: smallest V_TOTAL accepted at LOAD.

Ports:
- PCLK_i  in  1  pixel clock; the only clock.
- reset_n  in  1  reset, asynchronous assert, active-low.
- enable_i  in  1  run timing generator.
- resync_i  in  1  one-cycle framelock pulse.
- hv_out_config  in  32  [11:0] H_TOTAL, [23:12] H_ACTIVE, [31:24] H_SYNCLEN.
- hv_out_config2  in  32  [8:0] H_BACKPORCH, [19:9] V_TOTAL, [30:20] V_ACTIVE, [31] INTERLACED.
- hv_out_config3  in  32  [3:0] V_SYNCLEN, [12:4] V_BACKPORCH, [23:13] V_SOF_LINE, [31:24] V_RESYNC_LINE.
- HSYNC_o  out  1  active-low hsync.
- VSYNC_o  out  1  active-low vsync.
- DE_o  out  1  active video.
- FID_o  out  1  field id; 1 = odd, 0 = even.
- xpos_o  out  11  h_cnt - H_SYNCLEN - H_BACKPORCH, truncated.
- ypos_o  out  11  v_cnt - V_SYNCLEN - V_BACKPORCH, truncated.
- sof_o  out  1  one-cycle pulse at v_cnt==V_SOF_LINE, h_cnt==0.
- config_err_o  out  1  sticky until the next successful LOAD.

Behaviour:
- Reset state: FSM IDLE; h_cnt=0, v_cnt=0, HSYNC_o=1, VSYNC_o=1, DE_o=0, FID_o=1, xpos_o=0, ypos_o=0, sof_o=0, config_err_o=0.
- FSM IDLE: counters held at 0, outputs at reset values. enable_i=1 -> LOAD.
- FSM LOAD (1 cycle): all three config words latched into shadow registers. If H_TOTAL<CFG_MIN_HTOTAL or V_TOTAL<CFG_MIN_VTOTAL: config_err_o=1, stay in LOAD and retry every cycle. Otherwise clear config_err_o, h_cnt=0, v_cnt=0, FID=1, go to RUN.
- FSM RUN: h_cnt counts 0..H_TOTAL-1 and wraps, incrementing v_cnt. At the last pixel of the last line of a field, go to LOAD, so config changes only take effect at a frame boundary. The LOAD cycle is a one-pixel stretch, tolerated by downstream.
- enable_i=0 in any state -> IDLE next cycle; outputs return to reset values one cycle later.
- Progressive field length is V_TOTAL lines.
- Interlaced field lengths (only with the optional feature): FID=1 field is (V_TOTAL+1)>>1 lines, FID=0 field is V_TOTAL>>1 lines. FID toggles at each field end.
- Only the field end after a FID=0 field passes through LOAD; the FID=1 field end goes directly to the FID=0 field, v_cnt=0.
- HSYNC_o low when h_cnt<H_SYNCLEN.
- VSYNC_o in FID=1 (and progressive) fields: falls at h_cnt==0 of v_cnt==0, rises at h_cnt==0 of v_cnt==V_SYNCLEN.
- VSYNC_o in FID=0 fields: both edges at h_cnt==H_TOTAL>>1 of the same lines. This matches the half-line odd/even classification in the capture frontend.
- DE_o = (h_cnt in [HS+HBP, HS+HBP+H_ACTIVE)) & (v_cnt in [VS+VBP, VS+VBP+V_ACTIVE)). Comparisons use 13-bit sums; no wrap.
- All outputs are registered: exactly 1 PCLK_i latency from counter state. xpos/ypos/DE are mutually aligned.
- resync_i in RUN: next cycle h_cnt=0, v_cnt=V_RESYNC_LINE, FID=1, and no LOAD occurs.
  - resync_i beats a simultaneous wrap or field end.
  - resync_i is ignored in IDLE and LOAD.
  - A V_RESYNC_LINE of V_TOTAL or more is clamped to 0.
- reset_n asserted mid-frame: immediate asynchronous return to the reset state; no partial pulses are guaranteed.

Optional Feature:
- Macro: HV_TX_INTERLACE_EN.
- Defined: INTERLACED bit honoured; FID alternation and half-line VSYNC as described.
- Undefined: INTERLACED ignored; always progressive; FID_o constant 1; half-line compare logic removed.

Test Plan:
- 480p config (H_TOTAL 858, H_ACTIVE 720, HS 62, HBP 57, V_TOTAL 525, V_ACTIVE 480, VS 6, VBP 30), enable -> HSYNC low 62 of every 858 cycles; VSYNC low 6 lines; 345600 DE cycles per frame; frame period 450451 cycles (450450 + LOAD); first DE at xpos 0/ypos 0; sof_o once per frame.
- 480i config (INTERLACED=1, V_ACTIVE 240, VS 3, VBP 15), macro defined -> fields alternate 263/262 lines; FID=0 VSYNC edges at h_cnt 429; FID toggles each field. Macro undefined -> 525-line progressive, FID_o=1.
- Change H_ACTIVE 720->704 mid-frame -> current frame keeps 720 DE per line; next frame 704.
- resync_i at v_cnt 100 with V_RESYNC_LINE 5 -> next cycle h_cnt 0, v_cnt 5, FID 1; output sequence continues from line 5. resync_i on the same cycle as frame end -> resync wins, no LOAD.
- H_TOTAL=8 -> config_err_o=1, outputs idle; rewrite 858 -> err clears, RUN next cycle.
- reset_n low mid-active -> HSYNC_o=VSYNC_o=1, DE_o=0 asynchronously; enable_i deasserted mid-line -> DE_o=0 within 2 cycles.
